// File: rtl/wave_render.sv
// Waveform rasteriser: trigger on a rising crossing, capture one sample per column, then paint a full frame into frame RAM port A.
// Optional graticule overlay is enabled by defining WAVE_GRID_EN.
module wave_render #(
  parameter int          H_PIX        = 300,
  parameter int          V_PIX        = 200,
  parameter logic [11:0] TRACE_COLOUR = 12'h0F0,
  parameter logic [11:0] BG_COLOUR    = 12'h000,
  parameter logic [11:0] GRID_COLOUR  = 12'h444,
  parameter int          AUTO_TIMEOUT = 65535
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        run,
  input  logic        sample_valid,
  input  logic [7:0]  sample,
  input  logic [7:0]  trig_level,
  output logic [15:0] addra,
  output logic [11:0] dina,
  output logic        wea,
  output logic        busy,
  output logic        frame_done
);
  localparam int XW = $clog2(H_PIX);
  localparam int YW = $clog2(V_PIX);

  typedef enum logic [2:0] {IDLE, WAIT_TRIG, CAPTURE, DRAW, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    prev;
  logic          prev_valid;
  logic [15:0]   tcnt;
  logic [XW-1:0] col, x, x_left;
  logic [YW-1:0] y, r_cur, r_left, r_lo, r_hi;
  logic [15:0]   addr;
  logic [7:0]    sbuf [H_PIX];
  logic          trig_hit, timeout_hit, cap_start, cap_last, last_pix, grid_hit;
  logic [11:0]   pix_colour;

  // Screen row for an ADC code: full scale at the top, zero at the bottom.
  function automatic logic [YW-1:0] row_of(input logic [7:0] s);
    logic [15:0] prod;
    prod   = 16'(s) * 16'(V_PIX);
    row_of = YW'(V_PIX - 1) - YW'(prod >> 8);
  endfunction

  assign trig_hit    = prev_valid && (prev < trig_level) && (sample >= trig_level);
  assign timeout_hit = (tcnt == 16'(AUTO_TIMEOUT - 1));
  assign cap_start   = (state == WAIT_TRIG) && sample_valid && (trig_hit || timeout_hit);
  assign cap_last    = (state == CAPTURE) && sample_valid && (col == XW'(H_PIX - 1));
  assign last_pix    = (x == XW'(H_PIX - 1)) && (y == YW'(V_PIX - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (run) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (cap_start) state_nxt = CAPTURE;
      CAPTURE:   if (cap_last) state_nxt = DRAW;
      DRAW:      if (last_pix) state_nxt = DONE;
      DONE:      state_nxt = run ? WAIT_TRIG : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      tcnt       <= '0;
      col        <= '0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          prev_valid <= 1'b0;
          tcnt       <= '0;
        end
        WAIT_TRIG: if (sample_valid) begin
          if (trig_hit || timeout_hit) begin
            col <= XW'(1);
          end else begin
            prev       <= sample;
            prev_valid <= 1'b1;
            tcnt       <= tcnt + 16'd1;
          end
        end
        CAPTURE: if (sample_valid) begin
          col <= col + 1'b1;
          if (cap_last) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
          end
        end
        DRAW: begin
          addr <= addr + 16'd1;
          if (x == XW'(H_PIX - 1)) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sample buffer is plain storage with no reset; it is always fully rewritten before DRAW reads it.
  always_ff @(posedge clk_vga) begin
    if (cap_start)
      sbuf[0] <= sample;
    else if (state == CAPTURE && sample_valid)
      sbuf[col] <= sample;
  end

`ifdef WAVE_GRID_EN
  logic [4:0] gx, gy;

  // Wrap counters track x%30 and y%25 alongside the raster position.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      gx <= '0;
      gy <= '0;
    end else if (cap_last) begin
      gx <= '0;
      gy <= '0;
    end else if (state == DRAW) begin
      if (x == XW'(H_PIX - 1)) begin
        gx <= '0;
        gy <= (gy == 5'd24) ? 5'd0 : gy + 5'd1;
      end else begin
        gx <= (gx == 5'd29) ? 5'd0 : gx + 5'd1;
      end
    end
  end

  assign grid_hit = (gx == 5'd0) || (gy == 5'd0);
`else
  assign grid_hit = 1'b0;
`endif

  // The trace joins the previous column's row to this column's row with a vertical span.
  always_comb begin
    x_left = (x == '0) ? x : x - 1'b1;
    r_cur  = row_of(sbuf[x]);
    r_left = row_of(sbuf[x_left]);
    r_lo   = (r_cur < r_left) ? r_cur : r_left;
    r_hi   = (r_cur < r_left) ? r_left : r_cur;
    if (y >= r_lo && y <= r_hi) pix_colour = TRACE_COLOUR;
    else if (grid_hit)          pix_colour = GRID_COLOUR;
    else                        pix_colour = BG_COLOUR;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      addra      <= '0;
      dina       <= '0;
      wea        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wea        <= (state == DRAW);
      frame_done <= (state == DONE);
      if (state == DRAW) begin
        addra <= addr;
        dina  <= pix_colour;
      end
    end
  end
endmodule

// File: tb/tb_wave_render.sv
// Randomised and directed bench for wave_render, checked every cycle against a frame-level model.
// Uses a narrowed frame (40 columns) and a short auto-trigger timeout to keep runs short.
module tb_wave_render;
  localparam int H = 40, V = 200, N = H * V, AUTO = 1000;
  localparam logic [11:0] TRACE = 12'h0F0, BG = 12'h000, GRID = 12'h444;

  logic        clk_vga = 1'b0, rst_n = 1'b0, run = 1'b0, sample_valid = 1'b0;
  logic [7:0]  sample = '0, trig_level = '0;
  logic [15:0] addra;
  logic [11:0] dina;
  logic        wea, busy, frame_done;

  wave_render #(.H_PIX(H), .V_PIX(V), .AUTO_TIMEOUT(AUTO)) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .run(run), .sample_valid(sample_valid),
    .sample(sample), .trig_level(trig_level), .addra(addra), .dina(dina),
    .wea(wea), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_vga = ~clk_vga;

  int n_cmp = 0, n_fail = 0;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      if (n_fail >= 100) finish_run();
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef enum {M_OFF, M_ARMED, M_CAP, M_DRAW} mode_t;
  mode_t       mode = M_OFF;
  int          pix = 0, last = -1, armed_cnt = 0;
  bit          done_now = 0;
  int          cap[$];
  logic [11:0] fb [N];
  int          writes = 0, done_count = 0;

  function automatic int row(input int s);
    return (V - 1) - (s * V) / 256;
  endfunction

  function automatic logic [11:0] colour(input int k);
    int px, py, a, b;
    px = k % H;
    py = k / H;
    b  = row(cap[px]);
    a  = (px == 0) ? b : row(cap[px - 1]);
    if ((py >= a && py <= b) || (py >= b && py <= a)) return TRACE;
`ifdef WAVE_GRID_EN
    if (px % 30 == 0 || py % 25 == 0) return GRID;
`endif
    return BG;
  endfunction

  task automatic model_reset();
    mode = M_OFF; pix = 0; last = -1; armed_cnt = 0; done_now = 0;
  endtask

  task automatic start_cap(input int s);
    cap.delete();
    cap.push_back(s);
    mode = M_CAP;
  endtask

  task automatic model_step();
    done_now = 0;
    case (mode)
      M_OFF: if (run) begin mode = M_ARMED; last = -1; armed_cnt = 0; end
      M_ARMED: if (sample_valid) begin
        if (last >= 0 && last < int'(trig_level) && int'(sample) >= int'(trig_level)) begin
          start_cap(int'(sample));
        end else begin
          last = int'(sample);
          armed_cnt++;
          if (armed_cnt == AUTO) start_cap(int'(sample));
        end
      end
      M_CAP: if (sample_valid) begin
        cap.push_back(int'(sample));
        if (cap.size() == H) begin mode = M_DRAW; pix = -1; end
      end
      M_DRAW: begin
        pix++;
        if (pix == N) begin
          done_now  = 1;
          mode      = run ? M_ARMED : M_OFF;
          last      = -1;
          armed_cnt = 0;
        end
      end
      default: ;
    endcase
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    logic        exp_wea;
    logic [30:0] exp_v, act_v;
    forever begin
      @(negedge clk_vga);
      if (!rst_n) model_reset();
      exp_wea = (mode == M_DRAW && pix >= 0 && pix < N);
      exp_v = {mode != M_OFF, done_now, exp_wea,
               exp_wea ? 16'(pix) : 16'h0, exp_wea ? colour(pix) : 12'h0};
      act_v = {busy, frame_done, wea,
               exp_wea ? addra : 16'h0, exp_wea ? dina : 12'h0};
      check("cycle{busy,done,wea,addr,dina}", 64'(act_v), 64'(exp_v));
      if (wea === 1'b1) begin
        writes++;
        if (int'(addra) < N) fb[addra] = dina;
      end
      if (frame_done === 1'b1) done_count++;
      @(posedge clk_vga);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic send(input int s);
    sample       = 8'(s);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    start = done_count;
    for (int i = 0; i < budget && done_count == start; i++) tick();
    check(name, 64'(done_count > start), 64'd1);
  endtask

  task automatic new_frame();
    writes = 0;
    done_count = 0;
  endtask

  initial begin
    int tr;
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_wea", 64'(wea), 64'd0);
    check("reset_addra", 64'(addra), 64'd0);
    check("reset_dina_done", 64'({dina, frame_done}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Ramp: trigger on 128, column 0 on row 99.
    new_frame();
    trig_level = 8'd128;
    run = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) send(i % 256);
    wait_done("ramp_frame_done", N + 500);
    repeat (5) tick();
    check("ramp_col0_row99", 64'(fb[99 * H]), 64'(TRACE));
    check("ramp_write_count", 64'(writes), 64'(N));
    check("ramp_single_done", 64'(done_count), 64'd1);

    // Flat 50 below threshold: forced capture, trace on row 160.
    new_frame();
    trig_level = 8'd200;
    for (int i = 0; i < AUTO + H - 1; i++) send(50);
    wait_done("timeout_frame_done", N + 100);
    check("flat_row160_x0", 64'(fb[160 * H]), 64'(TRACE));
    check("flat_row160_x17", 64'(fb[160 * H + 17]), 64'(TRACE));
    check("flat_row160_xlast", 64'(fb[160 * H + H - 1]), 64'(TRACE));
    check("flat_row161_bg", 64'(fb[161 * H + 5]), 64'(BG));
`ifdef WAVE_GRID_EN
    check("grid_x30_y10", 64'(fb[10 * H + 30]), 64'(GRID));
`else
    check("grid_x30_y10", 64'(fb[10 * H + 30]), 64'(BG));
`endif
    check("grid_x31_y10", 64'(fb[10 * H + 31]), 64'(BG));

    // Step 0 -> 255 between columns 9 and 10.
    new_frame();
    trig_level = 8'd1;
    send(0);
    send(1);
    for (int i = 1; i < 10; i++) send(0);
    for (int i = 10; i < H; i++) send(255);
    wait_done("step_frame_done", N + 100);
    tr = 0;
    for (int r = 0; r < V; r++) if (fb[r * H + 10] == TRACE) tr++;
    check("step_col10_trace_rows", 64'(tr), 64'(V));
    check("step_col9_row5_bg", 64'(fb[5 * H + 9]), 64'(BG));

    // Random frames with random strobe gaps and thresholds.
    for (int f = 0; f < 2; f++) begin
      int start, budget;
      start  = done_count;
      budget = 2 * (AUTO + H) + N + 100;
      trig_level = 8'($urandom_range(1, 255));
      for (int i = 0; i < budget && done_count == start; i++) begin
        sample       = 8'($urandom);
        sample_valid = 1'($urandom_range(0, 1));
        tick();
      end
      sample_valid = 1'b0;
      check("random_frame_done", 64'(done_count > start), 64'd1);
    end

    // run dropped during capture: frame completes, then idle.
    new_frame();
    trig_level = 8'd128;
    send(0);
    send(200);
    for (int i = 0; i < 5; i++) send(40 + i);
    run = 1'b0;
    for (int i = 0; i < H; i++) send(100);
    wait_done("rundrop_frame_done", N + 100);
    check("rundrop_busy_low", 64'(busy), 64'd0);
    check("rundrop_write_count", 64'(writes), 64'(N));
    for (int i = 0; i < 20; i++) send((i % 2) ? 250 : 0);
    check("rundrop_no_new_writes", 64'(writes), 64'(N));
    check("rundrop_still_idle", 64'(busy), 64'd0);

    // Reset in the middle of DRAW.
    run = 1'b1;
    tick();
    send(0);
    send(200);
    for (int i = 1; i < H; i++) send(100);
    run = 1'b0;
    tr = 0;
    for (int i = 0; i < N && !(wea === 1'b1 && addra == 16'd1000); i++) begin
      tick();
      tr++;
    end
    check("reached_addr_1000", 64'(addra), 64'd1000);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_wea", 64'(wea), 64'd0);
    check("async_reset_addra", 64'(addra), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    finish_run();
  end
endmodule
